// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch -> decode queue.
//   DATA_WIDTH  : width of instruction, pc, imm and pc_at_prediction fields
//   INDEX_WIDTH : predictor index width; global history carries 3 extra bits
//   fetch_entry_t : one fetched instruction and its prediction context
package fetch_queue_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int INDEX_WIDTH = 8;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    instruction;
    logic [DATA_WIDTH-1:0]    pc;
    logic [DATA_WIDTH-1:0]    imm;
    logic                     branch_prediction;
    logic [DATA_WIDTH-1:0]    pc_at_prediction;
    logic [INDEX_WIDTH+2:0]   global_history;
    logic [2:0]               ras_tos;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_lane_compactor.sv
// Prefix-sum over the enqueue valid mask.
//   valid_i  : per-lane valid mask (may have holes)
//   offset_o : per lane, number of valid lanes strictly below it, i.e. the
//              slot offset from tail that lane would occupy if accepted
//   count_o  : popcount of valid_i
// Purely combinational.
module fetch_lane_compactor #(
  parameter  int LANES = 5,
  localparam int CW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]         valid_i,
  output logic [LANES-1:0][CW-1:0] offset_o,
  output logic [CW-1:0]            count_o
);

  logic [CW-1:0] sum;

  // Running sum rather than chained assigns keeps this a single
  // comb process with no self-referencing net.
  always_comb begin
    sum      = '0;
    offset_o = '0;
    for (int i = 0; i < LANES; i++) begin
      offset_o[i] = sum;
      sum         = sum + CW'(valid_i[i]);
    end
    count_o = sum;
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// Multi-lane circular queue between multi-fetch and decode.
//   clk, reset          : single clock, async active-high reset
//   flush_i             : drop everything, pointers to 0 on next edge
//   enq_valid_i/entry_i : FETCH_WIDTH lanes in; valid lanes are compacted
//   enq_accept_cnt_o    : how many valid lanes (lowest first) were taken
//   enq_ready_o         : room for a full FETCH_WIDTH group
//   deq_valid_o/entry_o : oldest DECODE_WIDTH entries, thermometer valid
//   deq_ready_i         : per-lane decode ready; only a leading run retires
//   occupancy_o, empty_o, full_o, almost_full_o : status
// DEPTH must be a power of two and >= FETCH_WIDTH + DECODE_WIDTH.
module fetch_decode_queue
  import fetch_queue_pkg::*;
#(
  parameter  int FETCH_WIDTH        = 5,
  parameter  int DECODE_WIDTH       = 3,
  parameter  int DEPTH              = 16,
  parameter  int ALMOST_FULL_THRESH = DEPTH - FETCH_WIDTH,
  localparam int PTR_W              = $clog2(DEPTH),
  localparam int OCC_W              = PTR_W + 1,
  localparam int CNT_W              = $clog2(FETCH_WIDTH + 1),
  localparam int DCNT_W             = $clog2(DECODE_WIDTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush_i,
  input  logic         [FETCH_WIDTH-1:0]        enq_valid_i,
  input  fetch_entry_t [FETCH_WIDTH-1:0]        enq_entry_i,
  output logic         [CNT_W-1:0]              enq_accept_cnt_o,
  output logic                                  enq_ready_o,
  output logic         [DECODE_WIDTH-1:0]       deq_valid_o,
  output fetch_entry_t [DECODE_WIDTH-1:0]       deq_entry_o,
  input  logic         [DECODE_WIDTH-1:0]       deq_ready_i,
  output logic         [OCC_W-1:0]              occupancy_o,
  output logic                                  empty_o,
  output logic                                  full_o,
  output logic                                  almost_full_o
);

  logic [PTR_W-1:0] head, tail;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] free_cnt;

  fetch_entry_t storage [DEPTH];

  logic [FETCH_WIDTH-1:0][CNT_W-1:0] lane_off;
  logic [CNT_W-1:0]                  valid_cnt;
  logic [CNT_W-1:0]                  n_acc;
  logic [FETCH_WIDTH-1:0]            wr_en;
  logic [DCNT_W-1:0]                 m_deq;

  fetch_lane_compactor #(
    .LANES (FETCH_WIDTH)
  ) u_compact (
    .valid_i  (enq_valid_i),
    .offset_o (lane_off),
    .count_o  (valid_cnt)
  );

  // Room is judged on start-of-cycle occupancy only; entries leaving this
  // cycle do not make space for entries arriving this cycle.
  assign free_cnt = OCC_W'(DEPTH) - occ;

  always_comb begin
    n_acc = valid_cnt;
    if (OCC_W'(valid_cnt) > free_cnt) n_acc = CNT_W'(free_cnt);
    if (flush_i || reset)             n_acc = '0;
  end

  // A valid lane is written iff its compacted slot falls inside the
  // accepted count; higher valid lanes are dropped and re-fetched.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < FETCH_WIDTH; i++)
      wr_en[i] = enq_valid_i[i] && (lane_off[i] < n_acc);
  end

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_deq
    assign deq_valid_o[g] = !flush_i && (occ > OCC_W'(g));
    assign deq_entry_o[g] = storage[head + PTR_W'(g)];
  end

  // Only the unbroken run of handshakes from lane 0 retires.
  always_comb begin
    logic run;
    run   = 1'b1;
    m_deq = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      run   = run & deq_valid_o[i] & deq_ready_i[i];
      m_deq = m_deq + DCNT_W'(run);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (flush_i) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head + PTR_W'(m_deq);
      tail <= tail + PTR_W'(n_acc);
      occ  <= occ + OCC_W'(n_acc) - OCC_W'(m_deq);
    end
  end

  // Payload is not reset; n_acc already blocks writes under flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (wr_en[i]) storage[tail + PTR_W'(lane_off[i])] <= enq_entry_i[i];
  end

  assign enq_accept_cnt_o = n_acc;
  assign enq_ready_o      = free_cnt >= OCC_W'(FETCH_WIDTH);
  assign occupancy_o      = occ;
  assign empty_o          = occ == '0;
  assign full_o           = occ == OCC_W'(DEPTH);
  assign almost_full_o    = int'(occ) >= ALMOST_FULL_THRESH;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue at default parameters.
module tb_fetch_decode_queue;
  import fetch_queue_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush_i;
  logic [4:0]             enq_valid_i;
  fetch_entry_t [4:0]     enq_entry_i;
  logic [2:0]             enq_accept_cnt_o;
  logic                   enq_ready_o;
  logic [2:0]             deq_valid_o;
  fetch_entry_t [2:0]     deq_entry_o;
  logic [2:0]             deq_ready_i;
  logic [4:0]             occupancy_o;
  logic                   empty_o, full_o, almost_full_o;

  int checks = 0;
  int errors = 0;
  int enq_seq = 0;
  int dseq = 0;

  fetch_decode_queue dut (
    .clk              (clk),
    .reset            (reset),
    .flush_i          (flush_i),
    .enq_valid_i      (enq_valid_i),
    .enq_entry_i      (enq_entry_i),
    .enq_accept_cnt_o (enq_accept_cnt_o),
    .enq_ready_o      (enq_ready_o),
    .deq_valid_o      (deq_valid_o),
    .deq_entry_o      (deq_entry_o),
    .deq_ready_i      (deq_ready_i),
    .occupancy_o      (occupancy_o),
    .empty_o          (empty_o),
    .full_o           (full_o),
    .almost_full_o    (almost_full_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic fetch_entry_t mk(input int s);
    fetch_entry_t e;
    e.instruction       = 32'h13 + 32'(s);
    e.pc                = 32'(s * 4);
    e.imm               = 32'(s) ^ 32'hFFFF_0000;
    e.branch_prediction = s[0];
    e.pc_at_prediction  = 32'(s * 4 + 8);
    e.global_history    = s[10:0];
    e.ras_tos           = s[2:0];
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] m, input logic [2:0] r, input logic f);
    enq_valid_i = m;
    for (int i = 0; i < 5; i++) enq_entry_i[i] = mk(enq_seq + i);
    deq_ready_i = r;
    flush_i     = f;
    #1;
  endtask

  task automatic chk_heads(input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("head%0d_pc", i), deq_entry_o[i].pc, 32'((dseq + i) * 4));
  endtask

  // One clock with expected accept count and expected retire count.
  task automatic step(input logic [4:0] m, input logic [2:0] r, input logic f,
                      input int en, input int dm);
    drive(m, r, f);
    chk("accept", enq_accept_cnt_o, en);
    chk_heads(dm);
    cyc();
    enq_seq += en;
    dseq    += dm;
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; enq_valid_i = '0; deq_ready_i = '0;
    for (int i = 0; i < 5; i++) enq_entry_i[i] = mk(0);
    #2;
    enq_valid_i = 5'b11111;
    #1;
    chk("rst_accept", enq_accept_cnt_o, 0);
    chk("rst_deq_valid", deq_valid_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_afull", almost_full_o, 0);
    chk("rst_ready", enq_ready_o, 1);
    chk("rst_occ", occupancy_o, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Fill from empty
    drive(5'b11111, 3'b000, 1'b0);
    chk("no_bypass", deq_valid_o, 0);
    step(5'b11111, 3'b000, 1'b0, 5, 0);
    step(5'b11111, 3'b000, 1'b0, 5, 0);
    step(5'b11111, 3'b000, 1'b0, 5, 0);
    drive(5'b11111, 3'b000, 1'b0);
    chk("occ15_ready", enq_ready_o, 0);
    chk("occ15_afull", almost_full_o, 1);
    step(5'b11111, 3'b000, 1'b0, 1, 0);
    chk("fill_occ", occupancy_o, 16);
    chk("fill_full", full_o, 1);
    chk("fill_ready", enq_ready_o, 0);
    drive(5'b11111, 3'b000, 1'b0);
    chk("full_accept", enq_accept_cnt_o, 0);
    chk("full_deq_valid", deq_valid_o, 3'b111);

    // Drain to 4, then partial handshakes
    for (int k = 0; k < 4; k++) step(5'b0, 3'b111, 1'b0, 0, 3);
    chk("drain_occ", occupancy_o, 4);
    step(5'b0, 3'b101, 1'b0, 0, 1);
    chk("partial_occ", occupancy_o, 3);
    step(5'b0, 3'b010, 1'b0, 0, 0);
    chk("blocked_occ", occupancy_o, 3);
    drive(5'b0, 3'b111, 1'b0);
    chk("last3_valid", deq_valid_o, 3'b111);
    step(5'b0, 3'b111, 1'b0, 0, 3);
    chk("drained_occ", occupancy_o, 0);
    chk("drained_empty", empty_o, 1);

    // Compaction of a holey mask
    enq_valid_i = 5'b10101;
    for (int i = 0; i < 5; i++) enq_entry_i[i] = mk(i);
    deq_ready_i = 3'b000;
    #1;
    chk("cmp_accept", enq_accept_cnt_o, 3);
    cyc();
    enq_valid_i = '0;
    #1;
    chk("cmp_valid", deq_valid_o, 3'b111);
    chk("cmp_e0", deq_entry_o[0], mk(0));
    chk("cmp_e1", deq_entry_o[1], mk(2));
    chk("cmp_e2", deq_entry_o[2], mk(4));
    deq_ready_i = 3'b111;
    cyc();
    chk("cmp_occ", occupancy_o, 0);

    // Walk head/tail to 14, then fill to 15
    enq_seq = 100; dseq = 100;
    step(5'b11111, 3'b000, 1'b0, 5, 0);
    step(5'b11111, 3'b000, 1'b0, 5, 0);
    step(5'b00001, 3'b000, 1'b0, 1, 0);
    step(5'b0, 3'b111, 1'b0, 0, 3);
    step(5'b0, 3'b111, 1'b0, 0, 3);
    step(5'b0, 3'b111, 1'b0, 0, 3);
    step(5'b0, 3'b011, 1'b0, 0, 2);
    chk("walk_occ", occupancy_o, 0);
    step(5'b11111, 3'b000, 1'b0, 5, 0);
    step(5'b11111, 3'b000, 1'b0, 5, 0);
    step(5'b11111, 3'b000, 1'b0, 5, 0);
    chk("wrap_pre_occ", occupancy_o, 15);
    // Simultaneous enqueue/dequeue, heads at 14,15,0
    step(5'b00111, 3'b111, 1'b0, 1, 3);
    chk("wrap_occ", occupancy_o, 13);
    step(5'b0, 3'b111, 1'b0, 0, 3);
    step(5'b0, 3'b001, 1'b0, 0, 1);
    chk("pre_flush_occ", occupancy_o, 9);

    // Flush with traffic on both sides
    drive(5'b11111, 3'b111, 1'b1);
    chk("flush_deq_valid", deq_valid_o, 0);
    chk("flush_accept", enq_accept_cnt_o, 0);
    cyc();
    flush_i = 1'b0;
    chk("flush_occ", occupancy_o, 0);
    chk("flush_empty", empty_o, 1);

    // Async reset mid-cycle at occupancy 7
    enq_seq = 200; dseq = 200;
    step(5'b11111, 3'b000, 1'b0, 5, 0);
    step(5'b00011, 3'b000, 1'b0, 2, 0);
    chk("prerst_occ", occupancy_o, 7);
    enq_valid_i = '0;
    #2 reset = 1'b1;
    #1;
    chk("arst_occ", occupancy_o, 0);
    chk("arst_empty", empty_o, 1);
    chk("arst_deq_valid", deq_valid_o, 0);
    chk("arst_ready", enq_ready_o, 1);
    enq_valid_i = 5'b11111;
    #1;
    chk("arst_accept", enq_accept_cnt_o, 0);
    reset = 1'b0;
    enq_seq = 300; dseq = 300;
    step(5'b00001, 3'b000, 1'b0, 1, 0);
    chk("post_rst_occ", occupancy_o, 1);
    chk("post_rst_valid", deq_valid_o, 3'b001);
    chk_heads(1);
    chk("post_rst_idx0", dut.storage[0].pc, 32'd1200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
